// File: rtl/led_ctrl_pkg.sv
// Shared constants and helpers for the memory-mapped LED controller.
// The optional PWM path is selected elsewhere with LED_PWM_EN.
package led_ctrl_pkg;

    localparam logic [1:0] LED_REG_DATA = 2'd0;
    localparam logic [1:0] LED_REG_MODE = 2'd1;
    localparam logic [1:0] LED_REG_DUTY = 2'd2;
    localparam logic [1:0] LED_REG_DIV  = 2'd3;

    localparam int LED_PWM_W = 8;
    localparam logic [LED_PWM_W-1:0] LED_DUTY_RESET = 8'hFF;

    // Replace only the bytes whose enable is set; bit 0 of be covers [7:0].
    function automatic logic [31:0] led_byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/led_blink_prescaler.sv
// Blink prescaler: counts up to the divisor, then restarts and flips the blink phase.
// A divisor write restarts the count without disturbing the phase.
module led_blink_prescaler
    import led_ctrl_pkg::*;
#(
    parameter int BLINK_W = 24
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [BLINK_W-1:0] div,
    input  logic               clr,
    output logic               phase
);

    logic [BLINK_W-1:0] cnt_r;
    logic               phase_r;

    assign phase = phase_r;

    // Prescaler count and blink phase.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_r   <= {BLINK_W{1'b0}};
            phase_r <= 1'b0;
        end else if (clr) begin
            cnt_r   <= {BLINK_W{1'b0}};
            phase_r <= phase_r;
        end else if (cnt_r >= div) begin
            cnt_r   <= {BLINK_W{1'b0}};
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + BLINK_W'(1);
            phase_r <= phase_r;
        end
    end

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED bank with per-LED blink and optional global PWM brightness.
// Define LED_PWM_EN to build the DUTY register and PWM counter.
module mmio_led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int          NUM_LEDS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h10003FF0,
    parameter int          BLINK_W   = 24
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [29:0]         mem_addr,
    input  logic [31:0]         mem_data_in,
    input  logic [3:0]          mem_write_en,
    input  logic                halted,
    output logic [31:0]         rd_data,
    output logic                rd_hit,
    output logic [NUM_LEDS-1:0] leds
);

    logic                hit_s;
    logic [1:0]          sel_s;
    logic                wr_s;
    logic [31:0]         cur_s;
    logic [31:0]         merge_s;
    logic                phase_s;
    logic                pwm_on_s;
    logic [NUM_LEDS-1:0] data_r;
    logic [NUM_LEDS-1:0] mode_r;
    logic [BLINK_W-1:0]  div_r;
    logic [NUM_LEDS-1:0] leds_r;
    logic [31:0]         rd_data_r;
    logic                rd_hit_r;
    logic                unused_s;

    assign hit_s    = (mem_addr[29:2] == BASE_ADDR[31:4]);
    assign sel_s    = mem_addr[1:0];
    assign wr_s     = hit_s && !halted && (mem_write_en != 4'b0000);
    assign merge_s  = led_byte_merge(cur_s, mem_data_in, mem_write_en);
    assign unused_s = ^merge_s;

    assign rd_data = rd_data_r;
    assign rd_hit  = rd_hit_r;
    assign leds    = leds_r;

`ifdef LED_PWM_EN
    logic [LED_PWM_W-1:0] duty_r;
    logic [LED_PWM_W-1:0] pwm_cnt_r;

    assign pwm_on_s = (pwm_cnt_r < duty_r) || (duty_r == LED_DUTY_RESET);

    // Duty register and free-running PWM counter.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            duty_r    <= LED_DUTY_RESET;
            pwm_cnt_r <= {LED_PWM_W{1'b0}};
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
            if (wr_s && (sel_s == LED_REG_DUTY)) begin
                duty_r <= merge_s[LED_PWM_W-1:0];
            end else begin
                duty_r <= duty_r;
            end
        end
    end
`else
    assign pwm_on_s = 1'b1;
`endif

    // Current value of the addressed register, zero-extended.
    always_comb begin
        cur_s = 32'd0;
        case (sel_s)
            LED_REG_DATA: cur_s = 32'(data_r);
            LED_REG_MODE: cur_s = 32'(mode_r);
`ifdef LED_PWM_EN
            LED_REG_DUTY: cur_s = 32'(duty_r);
`else
            LED_REG_DUTY: cur_s = 32'd0;
`endif
            LED_REG_DIV:  cur_s = 32'(div_r);
            default:      cur_s = 32'd0;
        endcase
    end

    // DATA, MODE and DIV registers with byte-masked writes.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            data_r <= {NUM_LEDS{1'b0}};
            mode_r <= {NUM_LEDS{1'b0}};
            div_r  <= {BLINK_W{1'b1}};
        end else if (wr_s) begin
            case (sel_s)
                LED_REG_DATA: data_r <= merge_s[NUM_LEDS-1:0];
                LED_REG_MODE: mode_r <= merge_s[NUM_LEDS-1:0];
                LED_REG_DIV:  div_r  <= merge_s[BLINK_W-1:0];
                default:      div_r  <= div_r;
            endcase
        end else begin
            data_r <= data_r;
        end
    end

    led_blink_prescaler #(
        .BLINK_W (BLINK_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_b (rst_b),
        .div   (div_r),
        .clr   (wr_s && (sel_s == LED_REG_DIV)),
        .phase (phase_s)
    );

    // Registered LED drive and read-back; reads see the pre-write value.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            leds_r    <= {NUM_LEDS{1'b0}};
            rd_data_r <= 32'd0;
            rd_hit_r  <= 1'b0;
        end else begin
            leds_r    <= data_r & (~mode_r | {NUM_LEDS{phase_s}}) & {NUM_LEDS{pwm_on_s}};
            rd_data_r <= hit_s ? cur_s : 32'd0;
            rd_hit_r  <= hit_s;
        end
    end

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Self-checking bench for mmio_led_ctrl: vector table, blink/PWM/reset sequences and
// randomized traffic against a behavioural model.
module tb_mmio_led_ctrl;

    localparam int          NL   = 8;
    localparam int          BW   = 24;
    localparam logic [31:0] BASE = 32'h10003FF0;
`ifdef LED_PWM_EN
    localparam bit PWM_EN = 1'b1;
`else
    localparam bit PWM_EN = 1'b0;
`endif
    localparam logic [31:0] EXP_DUTY_RST = PWM_EN ? 32'h000000FF : 32'h00000000;

    localparam logic [29:0] A_DATA = 30'h04000FFC;
    localparam logic [29:0] A_MODE = 30'h04000FFD;
    localparam logic [29:0] A_DUTY = 30'h04000FFE;
    localparam logic [29:0] A_DIV  = 30'h04000FFF;
    localparam logic [29:0] A_OUT  = 30'h04001000;

    logic          clk = 1'b0;
    logic          rst_b;
    logic [29:0]   mem_addr;
    logic [31:0]   mem_data_in;
    logic [3:0]    mem_write_en;
    logic          halted;
    logic [31:0]   rd_data;
    logic          rd_hit;
    logic [NL-1:0] leds;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0]  m_data, m_mode, m_duty, m_leds;
    logic [23:0] m_div;
    int unsigned m_presc;
    logic        m_phase;
    int          m_pwm;
    logic [31:0] m_rd;
    logic        m_hit;

    always #5 clk = ~clk;

    mmio_led_ctrl #(
        .NUM_LEDS  (NL),
        .BASE_ADDR (BASE),
        .BLINK_W   (BW)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .halted       (halted),
        .rd_data      (rd_data),
        .rd_hit       (rd_hit),
        .leds         (leds)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_mode = 8'h00; m_duty = 8'hFF; m_leds = 8'h00;
        m_div = 24'hFFFFFF; m_presc = 0; m_phase = 1'b0; m_pwm = 0;
        m_rd = 32'h0; m_hit = 1'b0;
    endtask

    // One clock edge of the specified behaviour, computed from pre-edge state.
    task automatic model_step(input logic [29:0] a, input logic [31:0] d,
                              input logic [3:0] we, input logic h);
        logic        hit, wr, pwm_on;
        logic [1:0]  sel;
        logic [31:0] cur, nv;
        hit = (({2'b00, a}) >> 2) == (BASE >> 4);
        sel = a[1:0];
        case (sel)
            2'd0:    cur = {24'h0, m_data};
            2'd1:    cur = {24'h0, m_mode};
            2'd2:    cur = PWM_EN ? {24'h0, m_duty} : 32'h0;
            default: cur = {8'h0, m_div};
        endcase
        pwm_on = !PWM_EN || (m_pwm < int'(m_duty)) || (m_duty == 8'hFF);
        for (int i = 0; i < NL; i++)
            m_leds[i] = m_data[i] && (!m_mode[i] || m_phase) && pwm_on;
        m_rd  = hit ? cur : 32'h0;
        m_hit = hit;
        wr = hit && !h && (we != 4'b0000);
        if (wr && sel == 2'd3) m_presc = 0;
        else if (m_presc >= m_div) begin m_presc = 0; m_phase = !m_phase; end
        else m_presc++;
        nv = cur;
        for (int b = 0; b < 4; b++)
            if (we[b]) nv[8*b +: 8] = d[8*b +: 8];
        if (wr) begin
            case (sel)
                2'd0:    m_data = nv[7:0];
                2'd1:    m_mode = nv[7:0];
                2'd2:    if (PWM_EN) m_duty = nv[7:0];
                default: m_div = nv[23:0];
            endcase
        end
        m_pwm = (m_pwm + 1) % 256;
    endtask

    task automatic cycle(input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] we, input logic h);
        mem_addr = a; mem_data_in = d; mem_write_en = we; halted = h;
        @(posedge clk);
        model_step(a, d, we, h);
        #1;
        chk("leds", 32'(leds), 32'(m_leds));
        chk("rd_data", rd_data, m_rd);
        chk("rd_hit", 32'(rd_hit), 32'(m_hit));
    endtask

    task automatic idle();
        cycle(30'h0, 32'h0, 4'b0000, 1'b0);
    endtask

    task automatic pwm_count(input logic [7:0] duty, input int exp);
        int on;
        on = 0;
        cycle(A_DUTY, {24'h0, duty}, 4'b0001, 1'b0);
        idle();
        for (int k = 0; k < 256; k++) begin
            idle();
            on += int'(leds[0]);
        end
        chk("pwm_on_count", 32'(on), 32'(exp));
    endtask

    typedef struct {
        logic [29:0] addr;
        logic [31:0] wd;
        logic [3:0]  we;
        logic        h;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic [7:0]  exp_leds;
    } vec_t;

    vec_t vt[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int last_chg, toggles, k;
        logic prev;

        vt.push_back('{A_DATA, 32'h000000A5, 4'b0001, 1'b0, 32'h00000000, 1'b1, 8'h00});
        vt.push_back('{A_DATA, 32'h00000000, 4'b0000, 1'b0, 32'h000000A5, 1'b1, 8'hA5});
        vt.push_back('{A_DATA, 32'h000000FF, 4'b1111, 1'b1, 32'h000000A5, 1'b1, 8'hA5});
        vt.push_back('{A_DATA, 32'h00000000, 4'b0000, 1'b0, 32'h000000A5, 1'b1, 8'hA5});
        vt.push_back('{A_DIV,  32'h00001200, 4'b0010, 1'b0, 32'h00FFFFFF, 1'b1, 8'hA5});
        vt.push_back('{A_DIV,  32'h00000000, 4'b0000, 1'b0, 32'h00FF12FF, 1'b1, 8'hA5});
        vt.push_back('{A_OUT,  32'hFFFFFFFF, 4'b1111, 1'b0, 32'h00000000, 1'b0, 8'hA5});
        vt.push_back('{A_DIV,  32'h00000000, 4'b0000, 1'b0, 32'h00FF12FF, 1'b1, 8'hA5});
        vt.push_back('{A_DUTY, 32'h00000000, 4'b0000, 1'b0, EXP_DUTY_RST, 1'b1, 8'hA5});
        vt.push_back('{A_DATA, 32'hFFFFFF5A, 4'b1111, 1'b0, 32'h000000A5, 1'b1, 8'hA5});
        vt.push_back('{A_DATA, 32'h00000000, 4'b0000, 1'b0, 32'h0000005A, 1'b1, 8'h5A});
        vt.push_back('{A_MODE, 32'h00000000, 4'b0000, 1'b0, 32'h00000000, 1'b1, 8'h5A});

        rst_b = 1'b0; mem_addr = 30'h0; mem_data_in = 32'h0; mem_write_en = 4'b0000; halted = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_hit", 32'(rd_hit), 32'h0);
        #2 rst_b = 1'b1;

        foreach (vt[i]) begin
            cycle(vt[i].addr, vt[i].wd, vt[i].we, vt[i].h);
            chk("tbl_rd_data", rd_data, vt[i].exp_rd);
            chk("tbl_rd_hit", 32'(rd_hit), 32'(vt[i].exp_hit));
            chk("tbl_leds", 32'(leds), 32'(vt[i].exp_leds));
        end

        // blink with DIV = 3: half-period of 4 cycles
        cycle(A_DATA, 32'h1, 4'b1111, 1'b0);
        cycle(A_MODE, 32'h1, 4'b1111, 1'b0);
        cycle(A_DIV,  32'h3, 4'b1111, 1'b0);
        last_chg = -1; toggles = 0; prev = leds[0];
        for (int j = 0; j < 40; j++) begin
            idle();
            if (leds[0] != prev) begin
                if (last_chg >= 0) chk("blink_half", 32'(j - last_chg), 32'd4);
                last_chg = j; toggles++; prev = leds[0];
            end
        end
        chk("blink_toggles", 32'(toggles >= 8), 32'd1);

        // DIV rewrite two cycles after a toggle restarts the prescaler
        prev = leds[0]; k = 0;
        while (leds[0] == prev && k < 10) begin idle(); k++; end
        chk("blink_sync", 32'(leds[0] != prev), 32'd1);
        idle();
        cycle(A_DIV, 32'h3, 4'b1111, 1'b0);
        prev = leds[0]; k = 0;
        while (leds[0] == prev && k < 20) begin idle(); k++; end
        chk("div_restart", 32'(k), 32'd5);

        // PWM brightness
        cycle(A_MODE, 32'h0, 4'b1111, 1'b0);
        pwm_count(8'd64,  PWM_EN ? 64 : 256);
        pwm_count(8'd0,   PWM_EN ? 0 : 256);
        pwm_count(8'd255, 256);
        cycle(A_DUTY, 32'h0, 4'b0000, 1'b0);
        chk("duty_rd", rd_data, EXP_DUTY_RST);

        // randomized traffic
        for (int j = 0; j < 400; j++) begin
            int r;
            logic [31:0] d;
            r = $urandom_range(0, 4);
            d = (r == 3) ? 32'($urandom_range(0, 6)) : $urandom;
            cycle((r == 4) ? A_OUT : A_DATA + 30'(r), d, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0));
        end

        // reset in the middle of blinking
        cycle(A_DUTY, 32'hFF, 4'b1111, 1'b0);
        cycle(A_DIV,  32'h1,  4'b1111, 1'b0);
        cycle(A_MODE, 32'hF0, 4'b1111, 1'b0);
        cycle(A_DATA, 32'hFF, 4'b1111, 1'b0);
        idle(); idle(); idle();
        cycle(A_DATA, 32'h0, 4'b0000, 1'b0);
        chk("pre_rst_leds_nz", 32'(leds != 8'h00), 32'd1);
        chk("pre_rst_rd", rd_data, 32'h000000FF);
        rst_b = 1'b0;
        #2;
        chk("async_rst_leds", 32'(leds), 32'h0);
        chk("async_rst_rd_data", rd_data, 32'h0);
        chk("async_rst_rd_hit", 32'(rd_hit), 32'h0);
        model_reset();
        #2 rst_b = 1'b1;
        cycle(A_DUTY, 32'h0, 4'b0000, 1'b0);
        chk("post_rst_duty", rd_data, EXP_DUTY_RST);
        cycle(A_DIV, 32'h0, 4'b0000, 1'b0);
        chk("post_rst_div", rd_data, 32'h00FFFFFF);
        cycle(A_DATA, 32'h0, 4'b0000, 1'b0);
        chk("post_rst_data", rd_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_led_ctrl.md
# mmio_led_ctrl

Memory-mapped LED controller on the core's data-memory port, replacing the single hard-wired 8-bit LED store in the FPGA top level. Decodes a parametrised base address, holds a bank of up to 32 LED bits with per-LED static/blink mode and a global PWM brightness, and supports register read-back. Sits beside `mips_mem`, snooping the same `mem_addr` / `mem_data_in` / `mem_write_en` bus. Its read data is muxed into the core's load path by the top level.

## Interface
- `NUM_LEDS`, 8: LED count, 1..32.
- `BASE_ADDR`, 32'h10003FF0: byte base address; must be 16-byte aligned.
- `BLINK_W`, 24: prescaler and blink-divisor width, 1..32.
- `clk` input 1: single clock, nominally 50 MHz.
- `rst_b` input 1: asynchronous, active-low reset.
- `mem_addr` input 30: word address from core.
- `mem_data_in` input 32: store data from core.
- `mem_write_en` input 4: byte write enables; bit 0 is bits [7:0].
- `halted` input 1: core halted; writes ignored while high.
- `rd_data` output 32: registered read data for the previous cycle's address.
- `rd_hit` output 1: registered; high when the previous cycle's address was in this block's window.
- `leds` output NUM_LEDS: registered LED drive.

## Operation
- Window is `BASE_ADDR[31:4]`, matched on `mem_addr[29:2]`. `mem_addr[1:0]` selects the register:
  - 0 DATA: LED on/off, bits [NUM_LEDS-1:0].
  - 1 MODE: per-LED; 0 = static, 1 = blink.
  - 2 DUTY: PWM duty, bits [7:0].
  - 3 DIV: blink half-period in cycles, bits [BLINK_W-1:0].
- A write happens when the address is in the window, `!halted`, and `mem_write_en` is nonzero.
  - Only bytes whose enable is set are updated.
  - Bits above a register's width are ignored on write and read as 0.
- Reset values: DATA 0, MODE 0, DUTY 8'hFF, DIV all-ones, `leds` 0, `rd_data` 0, `rd_hit` 0, prescaler 0, blink phase 0, PWM counter 0.
- Prescaler:
  - Increments every cycle.
  - When prescaler ≥ DIV: prescaler clears to 0 and blink phase toggles. DIV = 0 therefore toggles every cycle.
  - Any write to DIV clears the prescaler in the same edge; the phase is unchanged.
- PWM:
  - 8-bit free-running counter, wraps 255→0.
  - `pwm_on` = (counter < DUTY) or (DUTY == 8'hFF).
  - DUTY 0 means LEDs are always off.
- LED output: `leds[i]` next = `DATA[i] & (MODE[i] ? phase : 1) & pwm_on`.
- Read: `rd_data` / `rd_hit` capture the selected register on every edge, regardless of `mem_write_en` or `halted`.
  - On a simultaneous read and write of the same register, `rd_data` returns the pre-write value.
- Reset asserted mid-operation clears all state immediately.

## Timing
- Write presented in cycle N → register updated at the end of N → `leds` reflect it at the end of N+1 (2-edge latency).
- Read address in cycle N → `rd_data` / `rd_hit` valid in cycle N+1.
- Blink full period = 2·(DIV+1) cycles.
- PWM period = 256 cycles.
- No stalls, no handshake. Every in-window access completes in one cycle.

## Configuration
- `LED_PWM_EN` defined: DUTY register and PWM counter are built as described.
- `LED_PWM_EN` undefined:
  - No PWM counter or DUTY storage.
  - `pwm_on` is constant 1.
  - DUTY writes are ignored; DUTY reads return 0.
  - `leds` = `DATA & (MODE ? phase : 1)`, with the same latency.

## Structure
- Shared package `led_ctrl_pkg`:
  - register index constants `LED_REG_DATA` / `MODE` / `DUTY` / `DIV` (0..3);
  - `LED_DUTY_RESET` = 8'hFF;
  - `LED_PWM_W` = 8.
- One natural sub-module, `led_blink_prescaler`: BLINK_W counter, DIV compare, clear-on-write input, phase output.

## Test plan
- Reset, then write DATA = 32'h000000A5 with `we` = 4'b0001 at 0x10003FF0 → `leds` = 8'hA5 two edges later; `rd_data` on a DATA read = 32'hA5.
- `halted` = 1, write DATA = 8'hFF → `leds` and DATA unchanged.
- DATA = 8'h01, MODE = 8'h01, DIV = 3 → `leds[0]` toggles every 4 cycles (period 8); a DIV rewrite mid-count restarts the prescaler from 0.
- DUTY = 64 → `leds[0]` high for exactly 64 of every 256 cycles. DUTY = 0 → never high. DUTY = 255 → always high. Without `LED_PWM_EN`: always high, DUTY reads 0.
- Byte-masked write to DIV with `we` = 4'b0010 and data 32'h0000_1200 → DIV[15:8] = 8'h12, other bytes unchanged. Address 0x10004000 → `rd_hit` = 0 and no register change.
- Assert `rst_b` low mid-blink → `leds`, `rd_data` and `rd_hit` go 0 immediately; DUTY reads 8'hFF after release.
